// File: rtl/temperature_averager.sv
// Block averager: accumulates 2**LOG2_N unsigned samples, then holds the mean until it is taken.
// Define TEMP_AVG_ROUND_EN to round half up instead of truncating the result.
module temperature_averager #(
  parameter int DATA_W = 32,
  parameter int LOG2_N = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam int ACC_W = DATA_W + LOG2_N;

  typedef enum logic {ACC, HOLD} state_t;

  state_t              state, state_next;
  logic [ACC_W-1:0]    acc, acc_next, sum;
  logic [LOG2_N-1:0]   cnt, cnt_next;
  logic [DATA_W-1:0]   out_next;
  logic                accept;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign sum       = acc + {{LOG2_N{1'b0}}, in_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACC;
      acc      <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      state    <= state_next;
      acc      <= acc_next;
      cnt      <= cnt_next;
      out_data <= out_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    out_next   = out_data;
    if (clear) begin
      // clear wins over everything; a sample offered alongside it is dropped
      state_next = ACC;
      acc_next   = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            if (&cnt) begin
`ifdef TEMP_AVG_ROUND_EN
              out_next = DATA_W'((sum + (ACC_W'(1) << (LOG2_N - 1))) >> LOG2_N);
`else
              out_next = DATA_W'(sum >> LOG2_N);
`endif
              acc_next   = '0;
              cnt_next   = '0;
              state_next = HOLD;
            end else begin
              acc_next = sum;
              cnt_next = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_next = ACC;
        end
        default: state_next = ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_temperature_averager.sv
// Scoreboard bench for temperature_averager (DATA_W=32, LOG2_N=6); expected
// averages are queued when the 64th sample is driven and popped when out_valid shows.
module tb_temperature_averager;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [63:0] m_sum = '0;
  int          m_cnt = 0;
  logic [31:0] held;

  temperature_averager #(.DATA_W(32), .LOG2_N(6)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model_avg(input logic [63:0] s);
`ifdef TEMP_AVG_ROUND_EN
    return 32'((s + 64'd32) >> 6);
`else
    return 32'(s >> 6);
`endif
  endfunction

  task automatic model_accept(input logic [31:0] d);
    m_sum = m_sum + {32'd0, d};
    m_cnt++;
    if (m_cnt == 64) begin
      exp_q.push_back(model_avg(m_sum));
      m_sum = '0;
      m_cnt = 0;
    end
  endtask

  task automatic model_flush();
    m_sum = '0;
    m_cnt = 0;
  endtask

  // Drives n back-to-back samples; reports cycles where the DUT was not ready
  // or already claimed a result. Returns at the negedge after the last accept.
  task automatic feed(input int n, input bit ramp, input logic [31:0] base,
                      output int stalls, output int early);
    logic [31:0] d;
    stalls = 0;
    early  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (out_valid) early++;
      if (!in_ready) stalls++;
      d = ramp ? base + 32'(i) : base;
      model_accept(d);
      in_valid = 1'b1;
      in_data  = d;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_out_data: got %0h expected 0", out_data); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_constant();
    int stalls, early;
    logic [31:0] e;
    feed(64, 1'b0, 32'd100, stalls, early);
    checks++; if (stalls !== 0) begin errors++; $display("[TB] FAIL const_no_bubble: got %0d stalls expected 0", stalls); end
    checks++; if (early !== 0) begin errors++; $display("[TB] FAIL const_early_valid: got %0d expected 0", early); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL const_latency: out_valid %b expected 1", out_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++; if (out_data !== e) begin errors++; $display("[TB] FAIL const_data: got %0d expected %0d", out_data, e); end
  endtask

  task automatic test_hold();
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'd999;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++; if (out_data !== 32'd100) begin errors++; $display("[TB] FAIL hold_data[%0d]: got %0d expected 100", i, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready[%0d]: got %b expected 0", i, in_ready); end
    end
    in_valid = 1'b0;
    release_result();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL hold_release_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== held) begin errors++; $display("[TB] FAIL hold_keep_data: got %0d expected %0d", out_data, held); end
  endtask

  task automatic test_ramp();
    int stalls, early;
    logic [31:0] e, lit;
`ifdef TEMP_AVG_ROUND_EN
    lit = 32'd32;
`else
    lit = 32'd31;
`endif
    feed(64, 1'b1, 32'd0, stalls, early);
    checks++; if (stalls !== 0) begin errors++; $display("[TB] FAIL ramp_no_bubble: got %0d stalls expected 0", stalls); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ramp_latency: out_valid %b expected 1", out_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++; if (out_data !== e) begin errors++; $display("[TB] FAIL ramp_data: got %0d expected %0d", out_data, e); end
    checks++; if (out_data !== lit) begin errors++; $display("[TB] FAIL ramp_literal: got %0d expected %0d", out_data, lit); end
    release_result();
  endtask

  task automatic test_clear();
    int stalls, early;
    logic [31:0] e;
    feed(10, 1'b0, 32'd500, stalls, early);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd500;
    model_flush();
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL clear_ready: got %b expected 1", in_ready); end
    feed(63, 1'b0, 32'd7, stalls, early);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clear_63_valid: got %b expected 0", out_valid); end
    feed(1, 1'b0, 32'd7, stalls, early);
    checks++; if (early !== 0) begin errors++; $display("[TB] FAIL clear_early_valid: got %0d expected 0", early); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL clear_latency: out_valid %b expected 1", out_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++; if (out_data !== e) begin errors++; $display("[TB] FAIL clear_data: got %0d expected %0d", out_data, e); end
    release_result();
  endtask

  task automatic test_max();
    int stalls, early;
    logic [31:0] e;
    feed(64, 1'b0, 32'hFFFF_FFFF, stalls, early);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL max_latency: out_valid %b expected 1", out_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++; if (out_data !== e) begin errors++; $display("[TB] FAIL max_data: got %0h expected %0h", out_data, e); end
    checks++; if (out_data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL max_literal: got %0h expected ffffffff", out_data); end
  endtask

  task automatic test_reset_mid();
    int stalls, early;
    logic [31:0] e;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_hold_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_hold_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== 32'd0) begin errors++; $display("[TB] FAIL rst_hold_data: got %0h expected 0", out_data); end
    @(negedge clk);
    rst_n = 1'b1;
    feed(30, 1'b0, 32'd9, stalls, early);
    rst_n = 1'b0;
    model_flush();
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    feed(63, 1'b0, 32'd42, stalls, early);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_63_valid: got %b expected 0", out_valid); end
    feed(1, 1'b0, 32'd42, stalls, early);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_latency: out_valid %b expected 1", out_valid); end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEADBEEF;
    checks++; if (out_data !== e) begin errors++; $display("[TB] FAIL rst_mid_data: got %0d expected %0d", out_data, e); end
  endtask

  task automatic test_clear_in_hold();
    held  = out_data;
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL clrhold_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL clrhold_ready: got %b expected 1", in_ready); end
    checks++; if (out_data !== 32'd42) begin errors++; $display("[TB] FAIL clrhold_data: got %0d expected 42", out_data); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_left: got %0d entries expected 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_hold();
    test_ramp();
    test_clear();
    test_max();
    test_reset_mid();
    test_clear_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
